pixel_window_feeder: RTL and testbench

//  Upstream feeder for the conv/pool/FC classifier datapath. Accepts a raster-order
//  8-bit pixel stream (one image, row by row) and produces stride-1 2x2 windows as the

---
 rtl/pixel_window_feeder.sv | 124 ++++++++++++
 tb/tb_pixel_window_feeder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_feeder.sv
// Raster pixel stream to stride-1 2x2 window feeder with one-row line buffer.
// Windows are registered and held under consumer backpressure.
module pixel_window_feeder #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      pix_in,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic [3:0][7:0] pixels,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            win_last,
    output logic            busy,
    output logic            frame_done
);

    // Handshake: pix_in moves on pix_valid && pix_ready, a window moves on
    // win_valid && win_ready; neither valid waits on its own ready.
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [7:0]     lb [IMG_W];
    logic [7:0]     prev_pix;
    logic [7:0]     top_prev;
    logic           all_in;
    logic           accept;
    logic           take;
    logic           col_last;
    logic           row_last;
    logic           has_window;

    assign accept     = pix_valid && pix_ready;
    assign take       = win_valid && win_ready;
    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign has_window = accept && (row != '0) && (col != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = FILL;
            FILL:   if (accept && (row == RW'(1)) && (col == '0)) state_d = STREAM;
            STREAM: if (take && win_last) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == FILL) || (state_q == STREAM);
        frame_done = (state_q == DONE);
        pix_ready  = busy && (!win_valid || win_ready) && !all_in;
    end

    // Line buffer contents need no reset: a column is always written before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[col] <= pix_in;
        end
    end

    // top_prev keeps the row-above value of the previous column, which the
    // buffer has already overwritten by the time the next pixel arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            all_in    <= 1'b0;
            prev_pix  <= '0;
            top_prev  <= '0;
            pixels    <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                col    <= '0;
                row    <= '0;
                all_in <= 1'b0;
            end
            if (accept) begin
                prev_pix <= pix_in;
                top_prev <= lb[col];
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row    <= '0;
                        all_in <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (has_window) begin
                pixels    <= {pix_in, prev_pix, lb[col], top_prev};
                win_valid <= 1'b1;
                win_last  <= row_last && col_last;
            end else if (take) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Bench for pixel_window_feeder: 3x3 and 6x6 instances share stimulus, and the
// windows seen are compared with windows computed straight from the image array.
module tb_pixel_window_feeder;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      pix_in;
    logic            pix_valid;
    logic            win_ready;
    logic            sel6;

    logic            pr3, wv3, wl3, bz3, fd3;
    logic            pr6, wv6, wl6, bz6, fd6;
    logic [3:0][7:0] px3, px6;

    logic            o_pr, o_wv, o_wl, o_bz, o_fd;
    logic [31:0]     o_px;

    int              vectors = 0;
    int              miscompares = 0;

    logic [7:0]      img [64];
    logic [31:0]     exp_q [$];
    logic [31:0]     got_q [$];
    logic            last_q [$];
    int              hold_err, stall_ready_err, early_done, after_ready_err, timeout;
    logic            done_seen, done_after, wv_after, busy_after;

    pixel_window_feeder #(.IMG_W(3), .IMG_H(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pr3), .pixels(px3), .win_valid(wv3), .win_ready(win_ready),
        .win_last(wl3), .busy(bz3), .frame_done(fd3)
    );

    pixel_window_feeder #(.IMG_W(6), .IMG_H(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pr6), .pixels(px6), .win_valid(wv6), .win_ready(win_ready),
        .win_last(wl6), .busy(bz6), .frame_done(fd6)
    );

    assign o_pr = sel6 ? pr6 : pr3;
    assign o_wv = sel6 ? wv6 : wv3;
    assign o_wl = sel6 ? wl6 : wl3;
    assign o_bz = sel6 ? bz6 : bz3;
    assign o_fd = sel6 ? fd6 : fd3;
    assign o_px = sel6 ? px6 : px3;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_in = 8'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // reference model: every 2x2 neighbourhood with (r,c) >= (1,1), raster order
    task automatic build_exp(input int w, input int h);
        exp_q.delete();
        for (int r = 1; r < h; r++)
            for (int c = 1; c < w; c++)
                exp_q.push_back({img[r*w+c], img[r*w+c-1], img[(r-1)*w+c], img[(r-1)*w+c-1]});
    endtask

    // driver: vmode 0=always valid 1=alternate 2=random; rmode 0=always ready
    // 1=3-cycle stall on 2nd window 2=random; records what the consumer sees
    task automatic drive_frame(input int w, input int h, input int vmode, input int rmode,
                               input int abort_after, input int start_at);
        int idx = 0, taken = 0, stall_left = 0, cyc = 0;
        bit stalled_done = 0, start_done = 0, prev_stall = 0, acc, tk;
        logic [31:0] held = '0;
        got_q.delete(); last_q.delete();
        hold_err = 0; stall_ready_err = 0; early_done = 0; after_ready_err = 0; timeout = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            if (cyc >= 3000) begin timeout = 1; break; end
            pix_valid = (idx < w*h) && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                                        (vmode == 2 && $urandom_range(0, 1) == 1));
            pix_in = (idx < w*h) ? img[idx] : 8'($urandom);
            if (rmode == 1 && o_wv && taken == 1 && !stalled_done) begin
                stall_left = 3; stalled_done = 1;
            end
            if (rmode == 1) win_ready = (stall_left == 0);
            else if (rmode == 2) win_ready = ($urandom_range(0, 2) != 0);
            else win_ready = 1'b1;
            if (stall_left > 0) stall_left--;
            start = (start_at >= 0) && (idx == start_at) && !start_done;
            if (start) start_done = 1;
            #1;
            if (prev_stall && o_wv && o_px !== held) hold_err++;
            if (o_wv && !win_ready && o_pr) stall_ready_err++;
            if (o_fd) early_done++;
            if (idx >= w*h && o_pr) after_ready_err++;
            prev_stall = o_wv && !win_ready;
            held = o_px;
            acc = pix_valid && o_pr;
            tk = o_wv && win_ready;
            if (tk) begin got_q.push_back(o_px); last_q.push_back(o_wl); taken++; end
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (abort_after > 0 && idx >= abort_after) break;
            if (tk && last_q[$] === 1'b1) break;
        end
        pix_valid = 1'b0; start = 1'b0; win_ready = 1'b1;
        if (abort_after == 0) begin
            #1;
            done_seen = o_fd;
            @(negedge clk);
            #1;
            done_after = o_fd; wv_after = o_wv; busy_after = o_bz;
        end
    endtask

    task automatic test_reset();
        pix_valid = 1'b1; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        pulse_reset();
        #1;
        vectors++;
        if ({pr3, wv3, wl3, bz3, fd3, px3} !== '0) begin
            miscompares++;
            $display("FAIL reset_3x3: outputs=%h required 0", {pr3, wv3, wl3, bz3, fd3, px3});
        end
        vectors++;
        if ({pr6, wv6, wl6, bz6, fd6, px6} !== '0) begin
            miscompares++;
            $display("FAIL reset_6x6: outputs=%h required 0", {pr6, wv6, wl6, bz6, fd6, px6});
        end
    endtask

    task automatic test_basic_3x3();
        sel6 = 1'b0; pulse_reset();
        for (int i = 0; i < 9; i++) img[i] = 8'(i + 1);
        build_exp(3, 3);
        drive_frame(3, 3, 0, 0, 0, -1);
        vectors++;
        if (got_q.size() !== exp_q.size() || timeout != 0) begin
            miscompares++;
            $display("FAIL basic_count: got %0d windows (timeout=%0d) required %0d", got_q.size(), timeout, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL basic_win%0d: got %h last=%b required %h last=%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        vectors++;
        if (done_seen !== 1'b1 || done_after !== 1'b0 || busy_after !== 1'b0 || wv_after !== 1'b0 ||
            early_done != 0 || after_ready_err != 0) begin
            miscompares++;
            $display("FAIL basic_done: done=%b next_done=%b busy=%b wv=%b early=%0d late_ready=%0d required 1 0 0 0 0 0",
                     done_seen, done_after, busy_after, wv_after, early_done, after_ready_err);
        end
    endtask

    task automatic test_full_6x6();
        sel6 = 1'b1; pulse_reset();
        for (int i = 0; i < 36; i++) img[i] = 8'(i);
        build_exp(6, 6);
        drive_frame(6, 6, 0, 0, 0, -1);
        vectors++;
        if (got_q.size() !== 25 || timeout != 0) begin
            miscompares++;
            $display("FAIL full6_count: got %0d windows (timeout=%0d) required 25", got_q.size(), timeout);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL full6_win%0d: got %h last=%b required %h", i, got_q[i], last_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_seen !== 1'b1 || done_after !== 1'b0 || busy_after !== 1'b0 || early_done != 0) begin
            miscompares++;
            $display("FAIL full6_done: done=%b next_done=%b busy=%b early=%0d required 1 0 0 0", done_seen, done_after, busy_after, early_done);
        end
    endtask

    task automatic test_stall();
        sel6 = 1'b0; pulse_reset();
        for (int i = 0; i < 9; i++) img[i] = 8'(i + 1);
        build_exp(3, 3);
        drive_frame(3, 3, 0, 1, 0, -1);
        vectors++;
        if (hold_err != 0 || stall_ready_err != 0) begin
            miscompares++;
            $display("FAIL stall_hold: hold_changes=%0d ready_in_stall=%0d required 0 0", hold_err, stall_ready_err);
        end
        vectors++;
        if (got_q.size() !== exp_q.size() || timeout != 0) begin
            miscompares++;
            $display("FAIL stall_count: got %0d windows required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL stall_win%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_seen !== 1'b1 || done_after !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: done=%b next_done=%b required 1 0", done_seen, done_after);
        end
    endtask

    task automatic test_valid_gaps();
        sel6 = 1'b0; pulse_reset();
        for (int i = 0; i < 9; i++) img[i] = 8'(i + 1);
        build_exp(3, 3);
        drive_frame(3, 3, 1, 0, 0, -1);
        vectors++;
        if (got_q.size() !== exp_q.size() || timeout != 0) begin
            miscompares++;
            $display("FAIL gaps_count: got %0d windows required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                miscompares++;
                $display("FAIL gaps_win%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_done: done=%b required 1", done_seen);
        end
    endtask

    task automatic test_reset_mid();
        int fd_count = 0;
        sel6 = 1'b0; pulse_reset();
        for (int i = 0; i < 9; i++) img[i] = 8'(i + 1);
        drive_frame(3, 3, 0, 0, 5, -1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({o_pr, o_wv, o_wl, o_bz, o_fd, o_px} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: outputs=%h required 0", {o_pr, o_wv, o_wl, o_bz, o_fd, o_px});
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (o_fd || o_bz) fd_count++;
        end
        vectors++;
        if (fd_count != 0) begin
            miscompares++;
            $display("FAIL midreset_nodone: done/busy cycles=%0d required 0", fd_count);
        end
        @(negedge clk);
        for (int i = 0; i < 9; i++) img[i] = 8'(i + 11);
        build_exp(3, 3);
        drive_frame(3, 3, 0, 0, 0, -1);
        vectors++;
        if (got_q.size() !== exp_q.size() || timeout != 0) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d windows required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_win%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int bad = 0;
        sel6 = 1'b0; pulse_reset();
        for (int k = 0; k < 4; k++) begin
            pix_valid = 1'b1; pix_in = 8'($urandom);
            #1;
            if (o_pr || o_wv || o_bz) bad++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_pix_valid: ready/valid/busy cycles=%0d required 0", bad);
        end
        for (int i = 0; i < 9; i++) img[i] = 8'($urandom);
        build_exp(3, 3);
        drive_frame(3, 3, 0, 0, 0, 4);
        vectors++;
        if (got_q.size() !== exp_q.size() || timeout != 0) begin
            miscompares++;
            $display("FAIL midstart_count: got %0d windows required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midstart_win%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int w;
        for (int k = 0; k < 4; k++) begin
            sel6 = k[0];
            w = sel6 ? 6 : 3;
            pulse_reset();
            for (int i = 0; i < w*w; i++) img[i] = 8'($urandom);
            build_exp(w, w);
            drive_frame(w, w, 2, 2, 0, -1);
            vectors++;
            if (got_q.size() !== exp_q.size() || timeout != 0 || hold_err != 0 || stall_ready_err != 0) begin
                miscompares++;
                $display("FAIL rand%0d_flow: got %0d windows hold=%0d stallready=%0d required %0d 0 0",
                         k, got_q.size(), hold_err, stall_ready_err, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                    miscompares++;
                    $display("FAIL rand%0d_win%0d: got %h last=%b required %h", k, i, got_q[i], last_q[i], exp_q[i]);
                end
            end
            vectors++;
            if (done_seen !== 1'b1 || done_after !== 1'b0 || busy_after !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_done: done=%b next_done=%b busy=%b required 1 0 0", k, done_seen, done_after, busy_after);
            end
        end
    endtask

    initial begin
        sel6 = 1'b0; rst = 1'b1; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1; pix_in = 8'h0;
        @(negedge clk);
        test_reset();
        test_basic_3x3();
        test_full_6x6();
        test_stall();
        test_valid_gaps();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
